// File: rtl/cpu_pkg.sv
// Shared CPU definitions used by the ALU-op decoder and the multiply/divide sequencer.
//   ALUOP_MULT / ALUOP_DIV : ALU op codes that route work to muldiv_seq
//   state_e                : sequencer FSM states
package cpu_pkg;

  localparam logic [2:0] ALUOP_MULT = 3'b101;
  localparam logic [2:0] ALUOP_DIV  = 3'b110;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/muldiv_step.sv
// One radix-2 iteration of the multiply/divide loop (purely combinational).
//   is_div_i : 0 = shift-add multiply step, 1 = restoring-divide step
//   hi_i     : product high word / partial remainder
//   lo_i     : product low word (multiplier bits) / dividend-quotient word
//   b_i      : multiplier / divisor
//   hi_o     : next high word / remainder
//   lo_o     : next low word / quotient
module muldiv_step #(
  parameter int unsigned WIDTH = 64
) (
  input  logic             is_div_i,
  input  logic [WIDTH-1:0] hi_i,
  input  logic [WIDTH-1:0] lo_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  logic [WIDTH:0] sum;    // hi + b with carry kept
  logic [WIDTH:0] r_sh;   // remainder after shifting in the next dividend bit
  logic [WIDTH:0] diff;
  logic           r_ge_b;

  always_comb begin
    sum    = {1'b0, hi_i} + (lo_i[0] ? {1'b0, b_i} : '0);
    r_sh   = {hi_i, lo_i[WIDTH-1]};
    // r < b holds between iterations, so r_sh < 2b and WIDTH+1 bits never overflow.
    r_ge_b = (r_sh >= {1'b0, b_i});
    diff   = r_sh - {1'b0, b_i};

    if (is_div_i) begin
      hi_o = r_ge_b ? diff[WIDTH-1:0] : r_sh[WIDTH-1:0];
      lo_o = {lo_i[WIDTH-2:0], r_ge_b};
    end else begin
      // Shift {carry, hi, lo} right by one.
      hi_o = sum[WIDTH:1];
      lo_o = {sum[0], lo_i[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_seq.sv
// Iterative unsigned multiply/divide sequencer; stalls the CPU while it runs.
//   clk, reset : clock, asynchronous active-high reset
//   start, op  : request and ALU op (MULT / DIV accepted, others ignored)
//   a, b       : operands, captured on accept
//   stall      : hold PC / RegWrite (accept cycle and RUN)
//   busy       : RUN state
//   done       : one-cycle pulse in DONE
//   y, y_hi    : product low/high, or quotient and 0
//   rem        : remainder (0 for MULT)
//   div0       : DIV with b == 0
module muldiv_seq
  import cpu_pkg::*;
#(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             stall,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] y_hi,
  output logic [WIDTH-1:0] rem,
  output logic             div0
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             is_div_q, is_div_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic [WIDTH-1:0] y_hi_q, y_hi_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             div0_q, div0_d;

  logic             accept;
  logic [WIDTH-1:0] step_hi, step_lo;

  muldiv_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .is_div_i(is_div_q),
    .hi_i    (hi_q),
    .lo_i    (lo_q),
    .b_i     (b_q),
    .hi_o    (step_hi),
    .lo_o    (step_lo)
  );

  always_comb begin
    accept   = (state_q == IDLE) && start && ((op == ALUOP_MULT) || (op == ALUOP_DIV));
    state_d  = state_q;
    cnt_d    = cnt_q;
    is_div_d = is_div_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    b_d      = b_q;
    y_d      = y_q;
    y_hi_d   = y_hi_q;
    rem_d    = rem_q;
    div0_d   = div0_q;

    case (state_q)
      IDLE: begin
        if (accept) begin
          is_div_d = (op == ALUOP_DIV);
          b_d      = b;
          hi_d     = '0;
          lo_d     = a;
          cnt_d    = CNT_W'(WIDTH - 1);
          if ((op == ALUOP_DIV) && (b == '0)) begin
            // Divide by zero skips the loop and reports immediately.
            state_d = DONE;
            y_d     = '1;
            y_hi_d  = '0;
            rem_d   = a;
            div0_d  = 1'b1;
          end else begin
            state_d = RUN;
          end
        end
      end
      RUN: begin
        hi_d = step_hi;
        lo_d = step_lo;
        if (cnt_q == '0) begin
          state_d = DONE;
          y_d     = step_lo;
          y_hi_d  = is_div_q ? '0 : step_hi;
          rem_d   = is_div_q ? step_hi : '0;
          div0_d  = 1'b0;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      is_div_q <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      b_q      <= '0;
      y_q      <= '0;
      y_hi_q   <= '0;
      rem_q    <= '0;
      div0_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      is_div_q <= is_div_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      b_q      <= b_d;
      y_q      <= y_d;
      y_hi_q   <= y_hi_d;
      rem_q    <= rem_d;
      div0_q   <= div0_d;
    end
  end

  assign busy  = (state_q == RUN);
  assign done  = (state_q == DONE);
  assign stall = accept | busy;
  assign y     = y_q;
  assign y_hi  = y_hi_q;
  assign rem   = rem_q;
  assign div0  = div0_q;

endmodule

// File: tb/tb_muldiv_seq.sv
module tb_muldiv_seq;

  localparam logic [2:0] OP_MULT = 3'b101;
  localparam logic [2:0] OP_DIV  = 3'b110;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [63:0] a, b;
  logic        stall, busy, done, div0;
  logic [63:0] y, y_hi, rem;

  int vectors     = 0;
  int miscompares = 0;

  typedef struct {
    logic [63:0] y;
    logic [63:0] y_hi;
    logic [63:0] rem;
    logic        div0;
    int          lat;
  } exp_t;

  exp_t        sb[$];
  logic [63:0] last_y;

  muldiv_seq dut (
    .clk  (clk),
    .reset(reset),
    .start(start),
    .op   (op),
    .a    (a),
    .b    (b),
    .stall(stall),
    .busy (busy),
    .done (done),
    .y    (y),
    .y_hi (y_hi),
    .rem  (rem),
    .div0 (div0)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [2:0] o, input logic [63:0] av, input logic [63:0] bv);
    exp_t        e;
    logic [127:0] p;
    e.div0 = 1'b0;
    e.lat  = 65;
    if (o == OP_MULT) begin
      p      = {64'd0, av} * {64'd0, bv};
      e.y    = p[63:0];
      e.y_hi = p[127:64];
      e.rem  = '0;
    end else if (bv == 64'd0) begin
      e.y    = '1;
      e.y_hi = '0;
      e.rem  = av;
      e.div0 = 1'b1;
      e.lat  = 1;
    end else begin
      e.y    = av / bv;
      e.y_hi = '0;
      e.rem  = av % bv;
    end
    return e;
  endfunction

  // Drive one operation, optionally poking start with other operands during RUN,
  // then compare latency, stall length and results against the scoreboard.
  task automatic run_op(input string tag, input logic [2:0] o, input logic [63:0] av,
                        input logic [63:0] bv, input bit noise);
    exp_t e;
    int   cyc;
    int   stall_cnt;
    sb.push_back(model(o, av, bv));
    @(negedge clk);
    start = 1'b1; op = o; a = av; b = bv;
    #1;
    stall_cnt = stall ? 1 : 0;
    @(posedge clk);
    #1;
    start = 1'b0;
    a = {$urandom, $urandom};
    b = {$urandom, $urandom};
    cyc = 1;
    while (!done && cyc < 200) begin
      if (stall) stall_cnt++;
      start = noise && (cyc < 10);
      op    = OP_MULT;
      @(posedge clk);
      #1;
      cyc++;
    end
    start = 1'b0;
    e = sb.pop_front();
    check({tag, "_done"},  {63'd0, done},   64'd1);
    check({tag, "_lat"},   64'(cyc),        64'(e.lat));
    check({tag, "_stall"}, 64'(stall_cnt),  64'(e.lat));
    check({tag, "_stall_in_done"}, {63'd0, stall}, 64'd0);
    check({tag, "_y"},     y,               e.y);
    check({tag, "_y_hi"},  y_hi,            e.y_hi);
    check({tag, "_rem"},   rem,             e.rem);
    check({tag, "_div0"},  {63'd0, div0},   {63'd0, e.div0});
    last_y = e.y;
    @(posedge clk);
    #1;
    check({tag, "_idle_after"}, {62'd0, busy, done}, 64'd0);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; op = '0; a = '0; b = '0;
    #12;
    check("rst_outputs", {60'd0, stall, busy, done, div0}, 64'd0);
    check("rst_y", y | y_hi | rem, 64'd0);
    @(negedge clk);
    reset = 1'b0;

    run_op("mul_7x6",  OP_MULT, 64'd7, 64'd6, 1'b0);
    run_op("mul_max2", OP_MULT, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 1'b0);
    run_op("div_100_7", OP_DIV, 64'd100, 64'd7, 1'b0);
    run_op("div_5_9",  OP_DIV,  64'd5, 64'd9, 1'b0);
    run_op("div_5_0",  OP_DIV,  64'd5, 64'd0, 1'b0);
    run_op("mul_noise", OP_MULT, 64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b1);
    run_op("div_big",  OP_DIV,  64'hFFFF_FFFF_FFFF_FFFF, 64'h1_0000_0003, 1'b0);

    // Invalid op in IDLE: no stall, no start of work, result held.
    @(negedge clk);
    start = 1'b1; op = 3'b000; a = 64'd11; b = 64'd13;
    #1;
    check("badop_stall", {63'd0, stall}, 64'd0);
    @(posedge clk);
    #1;
    start = 1'b0;
    check("badop_state", {62'd0, busy, done}, 64'd0);
    check("badop_y_held", y, last_y);

    // Reset in cycle 30 of a MULT aborts it immediately.
    @(negedge clk);
    start = 1'b1; op = OP_MULT; a = 64'd1000; b = 64'd1000;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (29) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("arst_ctrl", {60'd0, stall, busy, done, div0}, 64'd0);
    check("arst_y", y | y_hi | rem, 64'd0);
    @(negedge clk);
    reset = 1'b0;
    run_op("mul_3x3", OP_MULT, 64'd3, 64'd3, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/muldiv_seq.md
# muldiv_seq

Iterative multiply/divide sequencer for the 64-bit single-cycle CPU. It takes MULT and DIV work off the combinational ALU path: it accepts one operation, runs a radix-2 shift-add or shift-subtract loop over WIDTH cycles, and asserts a stall so the PC and register-file write hold until the result is ready. It sits beside the ALU, is driven by the decoded ALU op and the rs/rt operands, and feeds the write-back mux.

## Interface
- WIDTH, 64, operand and result width; must be a power of two ≥ 8.
- CNT_W, $clog2(WIDTH), width of the iteration counter.
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- op  input  3  ALU op code: 3'b101 MULT, 3'b110 DIV; any other value with start is ignored.
- a  input  WIDTH  multiplicand / dividend (rs value), unsigned.
- b  input  WIDTH  multiplier / divisor (rt value), unsigned.
- stall  output  1  holds PC and RegWrite; combinational as described under Timing.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle pulse in DONE.
- y  output  WIDTH  product low word or quotient.
- y_hi  output  WIDTH  product high word; 0 for DIV.
- rem  output  WIDTH  remainder; 0 for MULT.
- div0  output  1  DIV with b == 0; valid with done.

## Operation
- States: IDLE, RUN, DONE.
- Accept condition: IDLE & start & (op == MULT | op == DIV). It latches op, a and b.
- IDLE → RUN on accept, except DIV with b == 0, which goes IDLE → DONE directly.
- RUN → DONE when the counter reaches 0. DONE → IDLE unconditionally, after exactly one cycle.
- MULT: 2·WIDTH-bit accumulator {hi, lo}.
  - Initialise hi = 0, lo = a.
  - Each iteration: if lo[0], hi += b with carry kept; then shift {carry, hi, lo} right by 1.
  - Result: y = lo, y_hi = hi.
- DIV: restoring division.
  - Initialise r = 0, q = a.
  - Each iteration: {r, q} <<= 1; if r ≥ b, r -= b and q[0] = 1.
  - Result: y = q, rem = r, y_hi = 0.
  - Use a WIDTH+1-bit subtract so there is no overflow.
- Divide by zero: y = all ones, rem = a, y_hi = 0, div0 = 1.
- Counter loads WIDTH-1 on accept and decrements once per RUN cycle, giving exactly WIDTH iterations. No wrap-around; it is only decremented in RUN.
- y, y_hi, rem and div0 update only on entry to DONE and hold until the next DONE.
- start in RUN or DONE is ignored. The requester re-presents start in IDLE; the CPU does this naturally because the PC is stalled.
- Operands are captured at accept; changes to a or b during RUN have no effect.

## Timing
- Reset value of every output is 0. State resets to IDLE and the counter to 0.
- Reset asserted mid-operation aborts the operation and discards the result. It takes effect immediately (asynchronous reset).
- Cycle 0 is the accept cycle; the state is IDLE.
- stall = (IDLE & accept condition) | RUN. It is low in DONE so the CPU writes back and advances that cycle.
- busy = RUN.
- MULT/DIV latency:
  - RUN occupies cycles 1..WIDTH.
  - done is high in cycle WIDTH+1.
  - stall is high for WIDTH+1 cycles.
- DIV by zero: done is high in cycle 1; stall is high in cycle 0 only.
- Back-to-back operations: a new accept is possible no earlier than the cycle after DONE, i.e. cycle WIDTH+2. start asserted during DONE is not accepted.

## Structure
- The shared package (cpu_pkg) holds the ALU op localparams ALUOP_MULT = 3'b101 and ALUOP_DIV = 3'b110, and the state enum {IDLE, RUN, DONE}.
- The CPU top-level ALU-op mapping uses the same constants.
- One sub-module is natural: muldiv_step, a combinational single-iteration step (add-shift or compare-subtract-shift selected by op). It keeps the FSM, counter and result registers in muldiv_seq readable.

## Test plan
- MULT, a=7, b=6 → stall high cycles 0..64, done in cycle 65, y=42, y_hi=0, rem=0, div0=0.
- MULT, a=64'hFFFF_FFFF_FFFF_FFFF, b=2 → y=64'hFFFF_FFFF_FFFF_FFFE, y_hi=1.
- DIV, a=100, b=7 → done in cycle 65, y=14, rem=2, y_hi=0, div0=0. Then DIV a=5, b=9 → y=0, rem=5.
- DIV, a=5, b=0 → done in cycle 1, div0=1, y=all ones, rem=5; stall high only in cycle 0.
- Second start in RUN with different operands, and start with op=3'b000 in IDLE → neither is accepted; the first result is unchanged and stall stays low for the invalid op.
- Assert reset in cycle 30 of a MULT → all outputs 0 and IDLE immediately. A fresh MULT 3×3 after release → y=9 with full WIDTH+1 latency.
